// File: rtl/trig_pkg.sv
// Shared types and defaults for the trigger arbiter.
package trig_pkg;

    localparam int SRC_NUM_DEF = 4;
    localparam int CNT_W_DEF   = 32;

    localparam int SRC_SOFT  = 0;
    localparam int SRC_LINE0 = 1;
    localparam int SRC_LINE1 = 2;
    localparam int SRC_ENC0  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_PULSE,
        ST_HOLDOFF
    } trig_state_e;

endpackage

// File: rtl/trig_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for one trigger line.
module trig_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic       s1;
    logic       s2;
    logic       prev;
    logic       armed;
    logic [1:0] fill;

    // Only arm once a real low has come through the synchronizer, so a
    // level already high at reset release never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            armed <= 1'b0;
            fill  <= 2'b00;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
            fill <= {fill[0], 1'b1};
            if (fill[1] && !s2) begin
                armed <= 1'b1;
            end
        end
    end

    assign rise = s2 & ~prev & armed;

endmodule

// File: rtl/trig_arbiter.sv
// Trigger arbiter: lowest-index grant, delay/pulse/holdoff sequencing.
// Optional drop counter port enabled by macro TRIG_DROP_CNT_EN.
module trig_arbiter
    import trig_pkg::*;
#(
    parameter int SRC_NUM = SRC_NUM_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int ID_W   = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SRC_NUM-1:0] trig_in,
    input  logic               reg_trig_arb_en,
    input  logic [SRC_NUM-1:0] reg_trig_src_en,
    input  logic [CNT_W-1:0]   reg_trig_delay,
    input  logic [CNT_W-1:0]   reg_trig_width,
    input  logic [CNT_W-1:0]   reg_trig_holdoff,
    output logic               trig_out,
    output logic [ID_W-1:0]    trig_src_id,
    output logic               trig_busy,
`ifdef TRIG_DROP_CNT_EN
    output logic [CNT_W-1:0]   trig_cnt,
    output logic [CNT_W-1:0]   trig_drop_cnt
`else
    output logic [CNT_W-1:0]   trig_cnt
`endif
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    trig_state_e        state;
    logic [SRC_NUM-1:0] rise;
    logic [SRC_NUM-1:0] req;
    logic               any_req;
    logic [ID_W-1:0]    grant_id;
    logic               arb_en_q;
    logic               en_rise;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   lat_width;
    logic [CNT_W-1:0]   lat_holdoff;
    logic [CNT_W-1:0]   cnt_base;

    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    for (genvar i = 0; i < SRC_NUM; i++) begin : g_sync
        trig_edge_sync u_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (trig_in[i]),
            .rise (rise[i])
        );
    end

    assign req     = rise & reg_trig_src_en;
    assign any_req = |req;
    assign en_rise = reg_trig_arb_en & ~arb_en_q;

    always_comb begin
        grant_id = '0;
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_id = ID_W'(i);
            end
        end
    end

    // A pulse entry in the same cycle as re-enable counts from zero.
    assign cnt_base = en_rise ? '0 : trig_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            trig_out    <= 1'b0;
            trig_busy   <= 1'b0;
            trig_src_id <= '0;
            trig_cnt    <= '0;
            cnt         <= '0;
            lat_width   <= '0;
            lat_holdoff <= '0;
            arb_en_q    <= 1'b0;
        end else begin
            arb_en_q <= reg_trig_arb_en;
            if (!reg_trig_arb_en) begin
                state     <= ST_IDLE;
                trig_out  <= 1'b0;
                trig_busy <= 1'b0;
                cnt       <= '0;
            end else begin
                trig_cnt <= cnt_base;
                unique case (state)
                    ST_IDLE: begin
                        if (any_req) begin
                            trig_src_id <= grant_id;
                            lat_width   <= reg_trig_width;
                            lat_holdoff <= reg_trig_holdoff;
                            trig_busy   <= 1'b1;
                            if (reg_trig_delay != '0) begin
                                state <= ST_DELAY;
                                cnt   <= reg_trig_delay - ONE;
                            end else begin
                                state    <= ST_PULSE;
                                trig_out <= 1'b1;
                                cnt      <= len_m1(reg_trig_width);
                                trig_cnt <= cnt_base + ONE;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (cnt == '0) begin
                            state    <= ST_PULSE;
                            trig_out <= 1'b1;
                            cnt      <= len_m1(lat_width);
                            trig_cnt <= cnt_base + ONE;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt == '0) begin
                            trig_out <= 1'b0;
                            if (lat_holdoff != '0) begin
                                state <= ST_HOLDOFF;
                                cnt   <= lat_holdoff - ONE;
                            end else begin
                                state     <= ST_IDLE;
                                trig_busy <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (cnt == '0) begin
                            state     <= ST_IDLE;
                            trig_busy <= 1'b0;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                endcase
            end
        end
    end

`ifdef TRIG_DROP_CNT_EN
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] n_drop;
    logic [CNT_W-1:0] drop_base;

    always_comb begin
        req_cnt = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            req_cnt = req_cnt + CNT_W'(req[i]);
        end
    end

    // In IDLE the granted edge is not a drop; elsewhere every edge is.
    assign n_drop    = (state == ST_IDLE) ? (any_req ? req_cnt - ONE : '0)
                                          : req_cnt;
    assign drop_base = en_rise ? '0 : trig_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_drop_cnt <= '0;
        end else if (reg_trig_arb_en) begin
            trig_drop_cnt <= drop_base + n_drop;
        end
    end
`endif

endmodule
